uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rr_picker.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_pkg                                                         |
// | Purpose : Shared FSM state type and sizing constants for uart_tx_arbiter.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_BITS_DEF = 8;
  localparam int IDX_W_DEF     = $clog2(NUM_REQ_DEF);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rr_picker                                                   |
// | Purpose : Rotating-priority pick: first set mask bit at or after start.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [IDX_W:0] pos;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // start < NUM_REQ and k < NUM_REQ, so one subtraction is enough to wrap
      pos = {1'b0, start} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM_REQ)) begin
        pos = pos - (IDX_W+1)'(NUM_REQ);
      end
      if (!valid && mask[pos[IDX_W-1:0]]) begin
        grant[pos[IDX_W-1:0]] = 1'b1;
        valid                 = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_arbiter                                                  |
// | Purpose : Round-robin arbiter feeding one byte at a time to a uart TX.     |
// |           Optional packet lock enabled by macro UART_ARB_LOCK_EN.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic [DATA_BITS-1:0]           tx_di,
  output logic                           tx_drdy,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic                           busy,
  output logic                           locked
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state;
  state_t               state_nxt;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   pick_grant;
  logic                 pick_valid;
  logic                 accept;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     ptr_nxt;
  logic [IDX_W-1:0]     win_idx;
  logic [DATA_BITS-1:0] win_data;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .mask  (eligible),
    .start (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        win_idx  = IDX_W'(i);
        win_data = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign ptr_nxt = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The accept pulse is suppressed while rst is high so an abandoned byte never re-pulses
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req_ready = '0;
    tx_drdy   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (pick_valid && !rst) begin
          accept    = 1'b1;
          req_ready = pick_grant;
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx_drdy = !tx_busy;
        if (tx_done) begin
          state_nxt = IDLE;
        end else if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_di    <= '0;
      grant_id <= '0;
      ptr      <= '0;
    end else if (accept) begin
      tx_di    <= win_data;
      grant_id <= win_idx;
      ptr      <= ptr_nxt;
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic             lock_q;
  logic             last_q;
  logic [IDX_W-1:0] lock_id;
  logic             done_to_idle;

  assign done_to_idle = (state != IDLE) && (state_nxt == IDLE);

  // Lock drops only once the LAST byte has actually finished on the wire
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
      lock_id <= '0;
    end else if (accept) begin
      last_q <= req_last[win_idx];
      if (!req_last[win_idx]) begin
        lock_q  <= 1'b1;
        lock_id <= win_idx;
      end
    end else if (done_to_idle && last_q) begin
      lock_q <= 1'b0;
      last_q <= 1'b0;
    end
  end

  assign eligible = lock_q ? (req_valid & (NUM_REQ'(1) << lock_id)) : req_valid;
  assign locked   = lock_q;
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign eligible    = req_valid;
  assign locked      = 1'b0;
`endif

endmodule
`default_nettype wire
